imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Pipelined, parametrised immediate-generation stage between fetch and decode/execute in the RV32I/RV64I core. It accepts one instruction word plus PC per cycle over a valid/ready handshake and decodes the instruction format. It emits the sign- or zero-extended immediate at XLEN width, along with a format code and an illegal-opcode flag. A registered output with a one-entry skid buffer gives full throughput under backpressure and a registered `in_ready`. A synchronous flush supports branch redirect.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `RV64`, `XLEN==64`, enables the OP-IMM-32 and OP-32 opcodes and the 6-bit shamt.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  synchronous; discards every held entry.
- `in_valid`  in  1  upstream holds valid data.
- `in_ready`  out  1  stage can accept data; a registered signal.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of the instruction.
- `out_valid`  out  1  output entry is valid.
- `out_ready`  in  1  downstream accepts the entry.
- `out_inst`  out  32  instruction, passed through.
- `out_pc`  out  XLEN  PC, passed through.
- `out_imm`  out  XLEN  decoded immediate.
- `out_fmt`  out  3  format code: 0 R/NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_illegal`  out  1  opcode is not in the supported set.

## Operation
- **Opcode to format, by `inst[6:0]`:**
  - U: 0110111 LUI, 0010111 AUIPC.
  - J: 1101111 JAL.
  - I: 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM, and 0011011 OP-IMM-32 when RV64.
  - B: 1100011.
  - S: 0100011.
  - R: 0110011 OP, and 0111011 OP-32 when RV64; immediate is 0.
- **Immediate construction.** All immediates are sign-extended from `inst[31]` to XLEN.
  - I = `inst[31:20]`.
  - S = `{inst[31:25], inst[11:7]}`.
  - B = `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U = `{inst[31:12], 12'b0}`.
  - J = `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- **Shift immediates.** For OP-IMM or OP-IMM-32 with funct3 001 or 101, `out_imm` is the zero-extended shamt:
  - `inst[24:20]` when XLEN=32 or for OP-IMM-32;
  - `inst[25:20]` when RV64 OP-IMM.
  - The funct7 bits never appear in `out_imm`.
- **Unsupported opcode:** `out_fmt`=0, `out_imm`=0, `out_illegal`=1. The entry still flows through and is never dropped.
- **Entry storage.** Two entries: main output register M and skid register K.
  - Accept into M when `in_valid && in_ready` and (M is empty or `out_ready`).
  - Otherwise an accepted input goes to K.
  - When M drains and K is full, K moves to M in the same edge.
- `in_ready` = K empty, registered.
- Ordering is strictly FIFO.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 entry per cycle while `out_ready` stays high.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.
- `in_ready` falls on the edge that fills K and rises on the edge that empties K.
- Reset (asynchronous): M and K are empty.
  - `out_valid`=0, `in_ready`=1.
  - `out_imm`, `out_pc` and `out_inst` are 0.
  - `out_fmt`=0, `out_illegal`=0.
  - Reset mid-transfer discards every entry.
- `flush` beats a simultaneous `in_valid` handshake: the input is not captured, M and K are empty next cycle, and `in_ready`=1.
- Simultaneous drain of M and a new accept with K empty: the new entry lands in M with no bubble.
- No combinational path runs from `out_ready` to `in_ready`.

## Structure
- Package `rv_imm_pkg` holds:
  - the opcode localparams;
  - the `imm_fmt_e` 3-bit enum;
  - the funct3 constants for shifts.
- Combinational sub-module `imm_extract`, parametrised by XLEN and RV64, maps an instruction to imm/fmt/illegal.
- The top level instantiates `imm_extract` once, on the input side, and registers its results.
- The top level also holds the M/K control.

## Test plan
- **U-type, XLEN=32:** LUI `0x12345037` → `out_imm`=`0x12345000`, fmt=4, one cycle later. AUIPC `0xFFFFF097` → `0xFFFFF000`.
- **J/B sign extension:** JAL `0xFFDFF06F` → `0xFFFFFFFC`, fmt=5. BEQ `0xFE000CE3` → `0xFFFFFFF8`, fmt=3.
- **Shift immediate:** SRAI `0x4030D093` → `out_imm`=3, not `0x403`. XLEN=64: LUI `0x80000037` → `0xFFFFFFFF80000000`.
- **Illegal opcode:** `0x0000007F` → `out_illegal`=1, `out_imm`=0, fmt=0, entry delivered.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0, then send two instructions.
  - `in_ready` goes 0 after the second is accepted; outputs stay stable.
  - On `out_ready`=1, both are delivered in order on consecutive cycles, then `in_ready`=1.
- **Flush and reset:**
  - Flush with M and K full plus `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, input not captured.
  - Asserting `rst_n`=0 mid-stream clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_imm_pkg.sv
// Shared RISC-V opcode, funct3 and immediate-format definitions for the
// immediate-generation stage.
package rv_imm_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational decode of one instruction word into immediate, format and illegal flag.
// Every immediate fits a sign-extended 32-bit value, widened to XLEN at the end.
module imm_extract
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;
  logic        is_opimm;

  assign opc = inst[6:0];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign is_opimm = (opc == OPC_OP_IMM) || (RV64 && (opc == OPC_OP_IMM_32));

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    imm32   = '0;
    unique case (opc)
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = imm_u;
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = imm_i;
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          fmt   = FMT_I;
          imm32 = imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = imm_b;
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = imm_s;
      end
      OPC_OP: begin
        fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        illegal = !RV64;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    // Shift-immediates carry funct7 in the upper bits; only the shamt is an operand.
    if (is_opimm && is_shift_f3(inst[14:12])) begin
      if (RV64 && (opc == OPC_OP_IMM)) imm32 = {26'b0, inst[25:20]};
      else                             imm32 = {27'b0, inst[24:20]};
    end
  end

  if (XLEN == 64) begin : g_x64
    assign imm = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: 1-cycle latency, full throughput.
// A one-entry skid register absorbs backpressure so in_ready comes straight from a flop.
module imm_gen_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  entry_t          in_ent;
  entry_t          m_q, m_d, k_q, k_d;
  logic            m_vld_q, m_vld_d, k_vld_q, k_vld_d;
  logic [XLEN-1:0] ext_imm;
  imm_fmt_e        ext_fmt;
  logic            ext_ill;
  logic            accept;
  logic            m_free;

  imm_extract #(
    .XLEN (XLEN),
    .RV64 (RV64)
  ) u_extract (
    .inst    (in_inst),
    .imm     (ext_imm),
    .fmt     (ext_fmt),
    .illegal (ext_ill)
  );

  always_comb begin
    in_ent.inst    = in_inst;
    in_ent.pc      = in_pc;
    in_ent.imm     = ext_imm;
    in_ent.fmt     = ext_fmt;
    in_ent.illegal = ext_ill;
  end

  assign accept = in_valid && !k_vld_q && !flush;
  assign m_free = !m_vld_q || out_ready;

  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (m_free) begin
      // K is older than anything on the input, so it refills M first.
      if (k_vld_q) begin
        m_d     = k_q;
        m_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else if (accept) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      k_d     = in_ent;
      k_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      k_q     <= '0;
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      k_q     <= k_d;
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
    end
  end

  assign in_ready    = !k_vld_q;
  assign out_valid   = m_vld_q;
  assign out_inst    = m_q.inst;
  assign out_pc      = m_q.pc;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: table-driven decode vectors through a scoreboard,
// plus hand sequences for latency, backpressure, flush and async reset.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  wire logic   out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] in_inst64;
  logic [63:0] in_pc64;
  logic        out_valid64;
  logic        out_ready64;
  logic [31:0] out_inst64;
  logic [63:0] out_pc64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic        out_illegal64;

  logic        rnd_en;
  logic        rnd_val;
  logic        ready_man;
  assign out_ready = rnd_en ? rnd_val : ready_man;

  int   total;
  int   bad;
  exp_t drv_exp;
  exp_t sb[$];
  vec_t tab32[14];
  vec_t tab64[5];

  imm_gen_stage #(.XLEN(32)) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_inst (in_inst), .in_pc (in_pc),
    .out_valid (out_valid), .out_ready (out_ready), .out_inst (out_inst),
    .out_pc (out_pc), .out_imm (out_imm), .out_fmt (out_fmt), .out_illegal (out_illegal)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk (clk), .rst_n (rst_n), .flush (flush64),
    .in_valid (in_valid64), .in_ready (in_ready64), .in_inst (in_inst64), .in_pc (in_pc64),
    .out_valid (out_valid64), .out_ready (out_ready64), .out_inst (out_inst64),
    .out_pc (out_pc64), .out_imm (out_imm64), .out_fmt (out_fmt64), .out_illegal (out_illegal64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_val = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rnd_val = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, got no event want event", nm);
  endtask

  // Scoreboard: push on an observed accept, pop on an observed transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (flush) begin
          sb.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_unexpected: got inst %h want none", out_inst);
            end else begin
              e = sb.pop_front();
              chk("sb_inst", 64'(out_inst), 64'(e.inst));
              chk("sb_pc",   64'(out_pc),   64'(e.pc));
              chk("sb_imm",  64'(out_imm),  64'(e.imm));
              chk("sb_fmt",  64'(out_fmt),  64'(e.fmt));
              chk("sb_ill",  64'(out_illegal), 64'(e.ill));
            end
          end
          if (in_valid && in_ready) sb.push_back(drv_exp);
        end
      end
    end
  end

  task automatic send(input vec_t v, input logic [31:0] pc);
    int n;
    in_valid      = 1'b1;
    in_inst       = v.inst;
    in_pc         = pc;
    drv_exp.inst  = v.inst;
    drv_exp.pc    = pc;
    drv_exp.imm   = v.imm[31:0];
    drv_exp.fmt   = v.fmt;
    drv_exp.ill   = v.ill;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("send_in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic send64(input vec_t v);
    @(posedge clk);
    #1;
    chk("x64_in_ready", 64'(in_ready64), 64'd1);
    in_valid64 = 1'b1;
    in_inst64  = v.inst;
    in_pc64    = 64'h8000_0000_0000_1000;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    chk("x64_valid", 64'(out_valid64), 64'd1);
    chk("x64_inst",  64'(out_inst64),  64'(v.inst));
    chk("x64_pc",    out_pc64,         64'h8000_0000_0000_1000);
    chk("x64_imm",   out_imm64,        v.imm);
    chk("x64_fmt",   64'(out_fmt64),   64'(v.fmt));
    chk("x64_ill",   64'(out_illegal64), 64'(v.ill));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tab32[0]  = '{32'h12345037, 64'h12345000, 3'd4, 1'b0};  // LUI
    tab32[1]  = '{32'hFFFFF097, 64'hFFFFF000, 3'd4, 1'b0};  // AUIPC
    tab32[2]  = '{32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0};  // JAL -4
    tab32[3]  = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0};  // BEQ -8
    tab32[4]  = '{32'h4030D093, 64'h00000003, 3'd1, 1'b0};  // SRAI 3
    tab32[5]  = '{32'h0000007F, 64'h00000000, 3'd0, 1'b1};  // unsupported
    tab32[6]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0};  // ADDI -1
    tab32[7]  = '{32'hFE20AE23, 64'hFFFFFFFC, 3'd2, 1'b0};  // SW -4
    tab32[8]  = '{32'h002081B3, 64'h00000000, 3'd0, 1'b0};  // ADD
    tab32[9]  = '{32'h0000003B, 64'h00000000, 3'd0, 1'b1};  // OP-32 on RV32
    tab32[10] = '{32'h01F09093, 64'h0000001F, 3'd1, 1'b0};  // SLLI 31
    tab32[11] = '{32'h7FF02083, 64'h000007FF, 3'd1, 1'b0};  // LW +2047
    tab32[12] = '{32'h00000073, 64'h00000000, 3'd1, 1'b0};  // ECALL
    tab32[13] = '{32'h800080E7, 64'hFFFFF800, 3'd1, 1'b0};  // JALR -2048
    tab64[0]  = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0};  // LUI
    tab64[1]  = '{32'h4230D093, 64'h0000000000000023, 3'd1, 1'b0};  // SRAI 35
    tab64[2]  = '{32'h4230D09B, 64'h0000000000000003, 3'd1, 1'b0};  // SRAIW, bit 25 ignored
    tab64[3]  = '{32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0};  // OP-32 legal
    tab64[4]  = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};  // JAL -4

    rnd_en      = 1'b0;
    ready_man   = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = '0;
    in_pc       = '0;
    flush64     = 1'b0;
    in_valid64  = 1'b0;
    in_inst64   = '0;
    in_pc64     = '0;
    out_ready64 = 1'b1;
    drv_exp     = '{32'h0, 32'h0, 32'h0, 3'd0, 1'b0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_inst",  64'(out_inst),  64'd0);
    chk("rst_out_fmt",   64'(out_fmt),   64'd0);
    chk("rst_out_ill",   64'(out_illegal), 64'd0);
    chk("rst_x64_imm",   out_imm64,      64'd0);
    #9 rst_n = 1'b1;

    // One-cycle latency on an idle stage.
    @(posedge clk);
    #1;
    chk("lat_idle_valid", 64'(out_valid), 64'd0);
    send(tab32[0], 32'h0000_0100);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_imm",   64'(out_imm),   64'h12345000);
    chk("lat_fmt",   64'(out_fmt),   64'd4);
    @(posedge clk);
    #1;
    chk("lat_empty", 64'(out_valid), 64'd0);

    // Table pass 1: downstream always ready, back-to-back issue.
    for (int i = 0; i < 14; i++) send(tab32[i], 32'h0000_1000 + 32'(i * 4));
    drain();

    // Table pass 2: random downstream stalls.
    rnd_en = 1'b1;
    for (int i = 0; i < 14; i++) send(tab32[i], 32'h0000_2000 + 32'(i * 4));
    rnd_en    = 1'b0;
    ready_man = 1'b1;
    drain();

    // Backpressure: two entries fill M and K, then release.
    ready_man = 1'b0;
    send(tab32[0], 32'h0000_3000);
    send(tab32[1], 32'h0000_3004);
    chk("bp_in_ready_low", 64'(in_ready),  64'd0);
    chk("bp_valid",        64'(out_valid), 64'd1);
    chk("bp_head_inst",    64'(out_inst),  64'(tab32[0].inst));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_inst",  64'(out_inst), 64'(tab32[0].inst));
    chk("bp_hold_imm",   64'(out_imm),  64'h12345000);
    chk("bp_hold_pc",    64'(out_pc),   64'h3000);
    chk("bp_hold_rdy",   64'(in_ready), 64'd0);
    ready_man = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second_inst", 64'(out_inst),  64'(tab32[1].inst));
    chk("bp_second_vld",  64'(out_valid), 64'd1);
    chk("bp_in_ready_hi", 64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    chk("bp_done_vld", 64'(out_valid), 64'd0);
    drain();

    // Flush with M and K full and a live input.
    ready_man = 1'b0;
    send(tab32[2], 32'h0000_4000);
    send(tab32[3], 32'h0000_4004);
    chk("fl_pre_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_inst  = tab32[4].inst;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    chk("fl_no_capture", 64'(out_valid), 64'd0);
    ready_man = 1'b1;

    // Asynchronous reset in the middle of a held transfer.
    ready_man = 1'b0;
    send(tab32[6], 32'h0000_5000);
    send(tab32[7], 32'h0000_5004);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_out_imm",   64'(out_imm),   64'd0);
    chk("arst_out_inst",  64'(out_inst),  64'd0);
    chk("arst_out_pc",    64'(out_pc),    64'd0);
    #2 rst_n = 1'b1;
    ready_man = 1'b1;
    @(posedge clk);
    #1;
    send(tab32[5], 32'h0000_6000);
    drain();

    // RV64 instance.
    for (int i = 0; i < 5; i++) send64(tab64[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
